rc4_key_dispatcher: RTL and testbench
=====================================

// Module: rc4_key_dispatcher
// PURPOSE
//  Central scheduler for the parallel RC4 key-search cores. Hands out candidate secret keys
//  one at a time to requesting cores (round-robin), tracks the key held by each core, and
//  raises a global stop when any core reports a correct decryption or the key space runs out.
//  Sits in the top level between the switch/LED glue and the CORE_COUNT rc4 core instances.
// PARAMETERS
//  CORE_COUNT  4             number of search cores (>=1)
//  KEY_W       22            candidate key width (key bits [23:22] are always 0)
//  KEY_MIN     0             first key issued
//  KEY_MAX     2**KEY_W-1    last key issued (inclusive, KEY_MIN<=KEY_MAX)
// PORTS
//  clk             in   1              system clock (CLOCK_50)
//  reset           in   1              asynchronous, active-high reset
//  start           in   1              level; high arms/runs a search, low returns to IDLE
//  core_req        in   CORE_COUNT     core i idle and wants a new key
//  core_busy       in   CORE_COUNT     core i is processing its assigned key
//  core_found      in   CORE_COUNT     1-cycle pulse: core i's assigned key decrypts correctly
//  core_grant      out  CORE_COUNT     one-hot (or zero) 1-cycle grant
//  core_key        out  KEY_W          key for the granted core, valid while core_grant!=0
//  stop_all        out  1              abort all cores (FOUND or EXHAUST)
//  found           out  1              correct key located
//  exhausted       out  1              key space finished with no match
//  found_key       out  KEY_W          winning key, valid while found=1
//  keys_issued     out  KEY_W+1        number of keys granted this search
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, next_key=KEY_MIN, assigned_key[] = 0.
//  FSM: IDLE -> RUN on start=1 (next_key<=KEY_MIN, keys_issued<=0).
//   RUN: each cycle, if next_key<=KEY_MAX and any eligible req, grant rr winner; else no grant.
//    Eligible = core_req & ~core_grant (core granted last cycle is masked for one cycle).
//    Grant registered: req sampled cycle t -> core_grant/core_key in t+1; core drops req in t+1.
//    On grant: assigned_key[w]<=next_key, next_key++ (KEY_W+1-bit, no wrap), keys_issued++.
//    Round-robin pointer moves to winner+1 after each grant; starts at core 0.
//   RUN -> DRAIN when the grant of KEY_MAX issues. DRAIN: no grants.
//   DRAIN -> EXHAUST when core_busy==0 and no grant in flight (one cycle after last grant).
//   RUN/DRAIN -> FOUND on any core_found; found_key<=assigned_key[i], lowest index wins ties.
//   core_found has priority over a same-cycle grant (grant suppressed) and over EXHAUST.
//   FOUND/EXHAUST: sticky; stop_all=1, found/exhausted held; return to IDLE when start=0.
//   start=0 in RUN/DRAIN: abort to IDLE next cycle, stop_all pulses 1 cycle, flags stay 0.
//  stop_all = registered, asserted the cycle after entering FOUND/EXHAUST.
//  core_found in IDLE/FOUND/EXHAUST ignored. Reset mid-search: immediate IDLE, all cleared.
//  keys_issued saturates-free: max value KEY_MAX-KEY_MIN+1 fits in KEY_W+1 bits.
// CONFIGURATION
//  `ifdef KEY_DISPATCH_PERF_EN: adds output search_cycles [31:0]: counts clk cycles in
//   RUN+DRAIN, cleared on IDLE->RUN, frozen in FOUND/EXHAUST, saturates at 32'hFFFF_FFFF.
//  Without it: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package rc4_crack_pkg: KEY_W localparam, typedef logic [KEY_W-1:0] key_t,
//   typedef enum logic [2:0] {DSP_IDLE,DSP_RUN,DSP_DRAIN,DSP_FOUND,DSP_EXHAUST} dsp_state_t.
//  Sub-module rr_arbiter #(N): req/grant one-hot, pointer update on advance; one instance.
//  Per-core assigned_key array and FSM stay in this module.
// TESTING
//  1 CORE_COUNT=4, KEY_MAX=7, all req held/toggled, no found -> keys 0..7 each granted once,
//    grants rotate 0,1,2,3,0..; exhausted=1, stop_all=1, keys_issued=8.
//  2 Core 2 granted key 5, pulse core_found[2] -> found=1, found_key=5, stop_all next cycle,
//    no further grants.
//  3 core_found[1] and [3] same cycle (keys 9, 11) -> found_key=9.
//  4 Only core 0 requests continuously -> grants every 2nd cycle (masking), keys sequential.
//  5 Drop start mid-RUN after 3 grants -> IDLE, found=exhausted=0; restart -> key KEY_MIN
//    again, keys_issued restarts at 0.
//  6 Assert reset mid-DRAIN -> all outputs 0 same cycle (async); with PERF_EN, search_cycles=0.

Source files
------------

// File: rtl/rc4_crack_pkg.sv
// rc4_crack_pkg: shared key width, key type and dispatcher state encoding for the RC4 key search
package rc4_crack_pkg;

   localparam int KEY_W = 22;

   typedef logic [KEY_W-1:0] key_t;

   typedef enum logic [2:0] {
      DSP_IDLE,
      DSP_RUN,
      DSP_DRAIN,
      DSP_FOUND,
      DSP_EXHAUST
   } dsp_state_t;

endpackage

// File: rtl/rc4_key_dispatcher_rr_arbiter.sv
// rr_arbiter: round-robin arbiter; pointer moves past the winner whenever a grant is taken
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          advance,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          hit
);

   logic [IW-1:0]  ptr_q, ptr_d;
   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   int             off;
   int             sum;

   // Rotate requests so the pointer sits at bit 0, then take the lowest set bit
   always_comb begin
      dbl = {req, req} >> ptr_q;
      rot = dbl[N-1:0];
      hit = 1'b0;
      off = 0;
      for (int i = 0; i < N; i++) begin
         if (!hit && rot[i]) begin
            hit = 1'b1;
            off = i;
         end
      end
      sum = int'(ptr_q) + off;
      if (sum >= N) sum = sum - N;
      idx = IW'(sum);
      for (int i = 0; i < N; i++) gnt[i] = hit && (sum == i);
   end

   // Next pointer: back to 0 on a new search, one past the winner after a taken grant
   always_comb begin
      ptr_d = clr ? '0 :
              (advance && hit) ? ((sum == N - 1) ? '0 : IW'(sum + 1)) :
              ptr_q;
   end

   // Pointer register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/rc4_key_dispatcher.sv
// rc4_key_dispatcher: hands candidate keys round-robin to RC4 cores and raises stop on found/exhaust
// Optional build macro KEY_DISPATCH_PERF_EN adds the search_cycles performance counter output.
module rc4_key_dispatcher #(
   parameter int          CORE_COUNT = 4,
   parameter int          KEY_W      = 22,
   parameter int unsigned KEY_MIN    = 0,
   parameter int unsigned KEY_MAX    = 2**KEY_W - 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [CORE_COUNT-1:0] core_req,
   input  logic [CORE_COUNT-1:0] core_busy,
   input  logic [CORE_COUNT-1:0] core_found,
   output logic [CORE_COUNT-1:0] core_grant,
   output logic [KEY_W-1:0]      core_key,
   output logic                  stop_all,
   output logic                  found,
   output logic                  exhausted,
   output logic [KEY_W-1:0]      found_key,
`ifdef KEY_DISPATCH_PERF_EN
   output logic [31:0]           search_cycles,
`endif
   output logic [KEY_W:0]        keys_issued
);

   import rc4_crack_pkg::*;

   localparam int IW = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
   localparam logic [KEY_W:0] KMIN = (KEY_W+1)'(KEY_MIN);
   localparam logic [KEY_W:0] KMAX = (KEY_W+1)'(KEY_MAX);
   localparam logic [KEY_W:0] KONE = (KEY_W+1)'(1);

   dsp_state_t             state_q, state_d;
   logic [KEY_W:0]         next_key_q, next_key_d;
   logic [KEY_W:0]         issued_q, issued_d;
   logic [CORE_COUNT-1:0]  grant_q, grant_d;
   logic [KEY_W-1:0]       key_q, key_d;
   logic [KEY_W-1:0]       assigned_q [CORE_COUNT];
   logic [KEY_W-1:0]       assigned_d [CORE_COUNT];
   logic [KEY_W-1:0]       found_key_q, found_key_d;
   logic                   stop_q, stop_d;
   logic                   found_q, found_d;
   logic                   exh_q, exh_d;
   logic [CORE_COUNT-1:0]  arb_req, arb_gnt;
   logic [IW-1:0]          arb_idx;
   logic                   arb_hit, arb_adv, arb_clr;
   logic [IW-1:0]          fidx;

   // A core granted last cycle is still dropping its request, so mask it out
   assign arb_req = core_req & ~grant_q;

   rr_arbiter #(.N(CORE_COUNT), .IW(IW)) u_arb (
      .clk     (clk),
      .reset   (reset),
      .clr     (arb_clr),
      .advance (arb_adv),
      .req     (arb_req),
      .gnt     (arb_gnt),
      .idx     (arb_idx),
      .hit     (arb_hit)
   );

   // Lowest-index reporting core wins when several find at once
   always_comb begin
      fidx = '0;
      for (int i = CORE_COUNT - 1; i >= 0; i--) begin
         if (core_found[i]) fidx = IW'(i);
      end
   end

   // Search FSM: grant issue, key bookkeeping and terminal conditions
   always_comb begin
      state_d     = state_q;
      next_key_d  = next_key_q;
      issued_d    = issued_q;
      grant_d     = '0;
      key_d       = '0;
      assigned_d  = assigned_q;
      found_key_d = found_key_q;
      stop_d      = 1'b0;
      arb_adv     = 1'b0;
      arb_clr     = 1'b0;
      case (state_q)
         DSP_IDLE: begin
            if (start) begin
               state_d    = DSP_RUN;
               next_key_d = KMIN;
               issued_d   = '0;
               arb_clr    = 1'b1;
            end
         end
         DSP_RUN, DSP_DRAIN: begin
            if (!start) begin
               state_d = DSP_IDLE;
               stop_d  = 1'b1;
            end else if (|core_found) begin
               state_d     = DSP_FOUND;
               found_key_d = assigned_q[fidx];
            end else if (state_q == DSP_RUN) begin
               if (next_key_q <= KMAX && arb_hit) begin
                  grant_d             = arb_gnt;
                  key_d               = next_key_q[KEY_W-1:0];
                  assigned_d[arb_idx] = next_key_q[KEY_W-1:0];
                  next_key_d          = next_key_q + KONE;
                  issued_d            = issued_q + KONE;
                  arb_adv             = 1'b1;
                  if (next_key_q == KMAX) state_d = DSP_DRAIN;
               end
            end else if (core_busy == '0 && grant_q == '0) begin
               state_d = DSP_EXHAUST;
            end
         end
         default: begin
            stop_d = start;
            if (!start) state_d = DSP_IDLE;
         end
      endcase
      found_d = (state_d == DSP_FOUND);
      exh_d   = (state_d == DSP_EXHAUST);
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= DSP_IDLE;
         next_key_q  <= KMIN;
         issued_q    <= '0;
         grant_q     <= '0;
         key_q       <= '0;
         found_key_q <= '0;
         stop_q      <= 1'b0;
         found_q     <= 1'b0;
         exh_q       <= 1'b0;
         for (int i = 0; i < CORE_COUNT; i++) assigned_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         next_key_q  <= next_key_d;
         issued_q    <= issued_d;
         grant_q     <= grant_d;
         key_q       <= key_d;
         found_key_q <= found_key_d;
         stop_q      <= stop_d;
         found_q     <= found_d;
         exh_q       <= exh_d;
         assigned_q  <= assigned_d;
      end
   end

`ifdef KEY_DISPATCH_PERF_EN
   logic [31:0] cyc_q, cyc_d;

   // Cycles spent searching; restarts with each search, holds once the search ends
   always_comb begin
      cyc_d = (state_q == DSP_IDLE && state_d == DSP_RUN) ? '0 :
              ((state_q == DSP_RUN || state_q == DSP_DRAIN) && cyc_q != '1) ? cyc_q + 32'd1 :
              cyc_q;
   end

   // Search cycle counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cyc_q <= '0;
      else       cyc_q <= cyc_d;
   end

   assign search_cycles = cyc_q;
`endif

   assign core_grant  = grant_q;
   assign core_key    = key_q;
   assign stop_all    = stop_q;
   assign found       = found_q;
   assign exhausted   = exh_q;
   assign found_key   = found_key_q;
   assign keys_issued = issued_q;

endmodule

// File: tb/tb_rc4_key_dispatcher.sv
// tb_rc4_key_dispatcher: randomized self-checking bench for rc4_key_dispatcher (4 cores, keys 0..7)
module tb_rc4_key_dispatcher;

   localparam int CC   = 4;
   localparam int KW   = 22;
   localparam int KMIN = 0;
   localparam int KMAX = 7;

   logic          clk = 0;
   logic          reset = 0;
   logic          start = 0;
   logic [CC-1:0] core_req = '0;
   logic [CC-1:0] core_busy = '0;
   logic [CC-1:0] core_found = '0;
   logic [CC-1:0] core_grant;
   logic [KW-1:0] core_key;
   logic          stop_all;
   logic          found;
   logic          exhausted;
   logic [KW-1:0] found_key;
   logic [KW:0]   keys_issued;
`ifdef KEY_DISPATCH_PERF_EN
   logic [31:0]   search_cycles;
`endif

   int          checks = 0;
   int          errors = 0;
   int          m_ptr, m_next, m_key;
   logic [3:0]  m_g = '0;
   int          m_assigned [CC];
   bit          m_active = 0;

   rc4_key_dispatcher #(.CORE_COUNT(CC), .KEY_W(KW), .KEY_MIN(KMIN), .KEY_MAX(KMAX)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .core_req    (core_req),
      .core_busy   (core_busy),
      .core_found  (core_found),
      .core_grant  (core_grant),
      .core_key    (core_key),
      .stop_all    (stop_all),
      .found       (found),
      .exhausted   (exhausted),
      .found_key   (found_key),
`ifdef KEY_DISPATCH_PERF_EN
      .search_cycles (search_cycles),
`endif
      .keys_issued (keys_issued)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   // Reference: while a search is live, the first requester at/after the rotating pointer
   // (excluding last cycle's winner) gets the next key, until the key range is used up.
   task automatic tick();
      logic [3:0] elig;
      logic [3:0] ng;
      ng = '0;
      m_key = 0;
      if (m_active && m_next <= KMAX) begin
         elig = core_req & ~m_g;
         for (int i = 0; i < CC; i++) begin
            int c;
            c = (m_ptr + i) % CC;
            if (ng == 0 && elig[c]) begin
               ng[c] = 1'b1;
               m_key = m_next;
               m_assigned[c] = m_next;
               m_next++;
               m_ptr = (c + 1) % CC;
            end
         end
      end
      m_g = ng;
      @(posedge clk);
      #1;
   endtask

   task automatic begin_search();
      start = 1;
      m_active = 0;
      tick();
      m_active = 1;
      m_ptr = 0;
      m_next = KMIN;
   endtask

   task automatic end_search();
      start = 0;
      m_active = 0;
      tick();
   endtask

   task automatic test_reset();
      core_req = 4'($urandom);
      core_busy = 4'($urandom);
      #1 reset = 1;
      #2;
      checks++; if (core_grant !== 4'h0) begin errors++; $display("FAIL rst_grant got %h exp 0", core_grant); end
      checks++; if (core_key !== 22'h0) begin errors++; $display("FAIL rst_key got %h exp 0", core_key); end
      checks++; if (stop_all !== 1'b0) begin errors++; $display("FAIL rst_stop got %b exp 0", stop_all); end
      checks++; if (found !== 1'b0) begin errors++; $display("FAIL rst_found got %b exp 0", found); end
      checks++; if (exhausted !== 1'b0) begin errors++; $display("FAIL rst_exh got %b exp 0", exhausted); end
      checks++; if (found_key !== 22'h0) begin errors++; $display("FAIL rst_fkey got %h exp 0", found_key); end
      checks++; if (keys_issued !== 23'h0) begin errors++; $display("FAIL rst_issued got %h exp 0", keys_issued); end
      for (int i = 0; i < CC; i++) m_assigned[i] = 0;
      core_req = '0;
      core_busy = '0;
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_exhaust();
      int n;
      begin_search();
      for (int i = 0; i < 4; i++) begin
         core_req = 4'hF;
         tick();
         checks++; if (core_grant !== m_g) begin errors++; $display("FAIL held_grant got %h exp %h", core_grant, m_g); end
         checks++; if (core_grant !== 4'(1 << i)) begin errors++; $display("FAIL held_rot got %h exp %h", core_grant, 4'(1 << i)); end
         checks++; if (core_key !== 22'(i)) begin errors++; $display("FAIL held_key got %0d exp %0d", core_key, i); end
      end
      n = 0;
      while (m_next <= KMAX && n < 60) begin
         core_req = 4'($urandom);
         tick();
         n++;
         checks++; if (core_grant !== m_g) begin errors++; $display("FAIL tog_grant got %h exp %h", core_grant, m_g); end
         if (m_g != 0) begin
            checks++; if (core_key !== 22'(m_key)) begin errors++; $display("FAIL tog_key got %0d exp %0d", core_key, m_key); end
         end
      end
      core_req = 4'hF;
      n = 0;
      while (!exhausted && n < 6) begin
         tick();
         n++;
         checks++; if (core_grant !== 4'h0) begin errors++; $display("FAIL drain_grant got %h exp 0", core_grant); end
      end
      checks++; if (exhausted !== 1'b1) begin errors++; $display("FAIL exh_flag got %b exp 1", exhausted); end
      checks++; if (found !== 1'b0) begin errors++; $display("FAIL exh_found got %b exp 0", found); end
      checks++; if (keys_issued !== 23'(KMAX - KMIN + 1)) begin errors++; $display("FAIL exh_issued got %0d exp %0d", keys_issued, KMAX - KMIN + 1); end
      tick();
      checks++; if (stop_all !== 1'b1) begin errors++; $display("FAIL exh_stop got %b exp 1", stop_all); end
      checks++; if (exhausted !== 1'b1) begin errors++; $display("FAIL exh_sticky got %b exp 1", exhausted); end
      core_req = '0;
      end_search();
      checks++; if (exhausted !== 1'b0) begin errors++; $display("FAIL exh_clear got %b exp 0", exhausted); end
   endtask

   task automatic test_found();
      logic [3:0] pat [6];
      pat = '{4'b0011, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
      begin_search();
      for (int i = 0; i < 6; i++) begin
         core_req = pat[i];
         tick();
         checks++; if (core_grant !== m_g) begin errors++; $display("FAIL fnd_grant got %h exp %h", core_grant, m_g); end
      end
      checks++; if (core_grant !== 4'b0100 || core_key !== 22'd5) begin errors++; $display("FAIL fnd_setup got %h/%0d exp 4/5", core_grant, core_key); end
      core_req = '0;
      tick();
      core_req = 4'hF;
      core_found = 4'b0100;
      m_active = 0;
      tick();
      core_found = '0;
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL fnd_flag got %b exp 1", found); end
      checks++; if (found_key !== 22'd5) begin errors++; $display("FAIL fnd_key got %0d exp 5", found_key); end
      checks++; if (core_grant !== 4'h0) begin errors++; $display("FAIL fnd_suppress got %h exp 0", core_grant); end
      tick();
      checks++; if (stop_all !== 1'b1) begin errors++; $display("FAIL fnd_stop got %b exp 1", stop_all); end
      checks++; if (core_grant !== 4'h0) begin errors++; $display("FAIL fnd_nogrant got %h exp 0", core_grant); end
      core_req = '0;
      end_search();
      checks++; if (found !== 1'b0 || stop_all !== 1'b0) begin errors++; $display("FAIL fnd_idle got %b/%b exp 0/0", found, stop_all); end
   endtask

   task automatic test_tie();
      begin_search();
      core_req = 4'hF;
      for (int i = 0; i < 4; i++) tick();
      core_req = '0;
      core_found = 4'b1010;
      m_active = 0;
      tick();
      core_found = '0;
      checks++; if (found_key !== 22'd1) begin errors++; $display("FAIL tie_key got %0d exp 1", found_key); end
      checks++; if (found_key !== 22'(m_assigned[1])) begin errors++; $display("FAIL tie_model got %0d exp %0d", found_key, m_assigned[1]); end
      end_search();
   endtask

   task automatic test_single();
      begin_search();
      core_req = 4'b0001;
      for (int i = 0; i < 16; i++) begin
         tick();
         checks++; if (core_grant !== m_g) begin errors++; $display("FAIL one_grant got %h exp %h", core_grant, m_g); end
         checks++; if (core_grant !== 4'(i % 2 == 0)) begin errors++; $display("FAIL one_alt got %h exp %h", core_grant, 4'(i % 2 == 0)); end
         if (i % 2 == 0) begin
            checks++; if (core_key !== 22'(i / 2)) begin errors++; $display("FAIL one_key got %0d exp %0d", core_key, i / 2); end
         end
      end
      checks++; if (keys_issued !== 23'd8) begin errors++; $display("FAIL one_issued got %0d exp 8", keys_issued); end
      core_req = '0;
      end_search();
      checks++; if (stop_all !== 1'b1) begin errors++; $display("FAIL one_abort got %b exp 1", stop_all); end
      checks++; if (found !== 1'b0 || exhausted !== 1'b0) begin errors++; $display("FAIL one_flags got %b/%b exp 0/0", found, exhausted); end
      tick();
      checks++; if (stop_all !== 1'b0) begin errors++; $display("FAIL one_pulse got %b exp 0", stop_all); end
   endtask

   task automatic test_abort();
      begin_search();
      core_req = 4'hF;
      for (int i = 0; i < 3; i++) tick();
      checks++; if (keys_issued !== 23'd3) begin errors++; $display("FAIL ab_issued got %0d exp 3", keys_issued); end
      end_search();
      checks++; if (stop_all !== 1'b1) begin errors++; $display("FAIL ab_stop got %b exp 1", stop_all); end
      checks++; if (found !== 1'b0 || exhausted !== 1'b0) begin errors++; $display("FAIL ab_flags got %b/%b exp 0/0", found, exhausted); end
      checks++; if (core_grant !== 4'h0) begin errors++; $display("FAIL ab_grant got %h exp 0", core_grant); end
      tick();
      checks++; if (stop_all !== 1'b0) begin errors++; $display("FAIL ab_pulse got %b exp 1-cycle", stop_all); end
      begin_search();
      tick();
      checks++; if (core_grant !== 4'b0001) begin errors++; $display("FAIL ab_regrant got %h exp 1", core_grant); end
      checks++; if (core_key !== 22'(KMIN)) begin errors++; $display("FAIL ab_rekey got %0d exp %0d", core_key, KMIN); end
      checks++; if (keys_issued !== 23'd1) begin errors++; $display("FAIL ab_reissued got %0d exp 1", keys_issued); end
      core_req = '0;
      end_search();
      tick();
   endtask

   task automatic test_random();
      int n, low;
      logic [3:0] f;
      for (int s = 0; s < 4; s++) begin
         begin_search();
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) begin
            core_req = 4'($urandom);
            tick();
            checks++; if (core_grant !== m_g) begin errors++; $display("FAIL rnd_grant got %h exp %h", core_grant, m_g); end
            if (m_g != 0) begin
               checks++; if (core_key !== 22'(m_key)) begin errors++; $display("FAIL rnd_key got %0d exp %0d", core_key, m_key); end
            end
         end
         core_req = '0;
         tick();
         f = 4'($urandom_range(1, 15));
         low = 0;
         for (int i = CC - 1; i >= 0; i--) if (f[i]) low = i;
         core_found = f;
         m_active = 0;
         tick();
         core_found = '0;
         checks++; if (found !== 1'b1) begin errors++; $display("FAIL rnd_found got %b exp 1", found); end
         checks++; if (found_key !== 22'(m_assigned[low])) begin errors++; $display("FAIL rnd_fkey got %0d exp %0d", found_key, m_assigned[low]); end
         end_search();
      end
   endtask

   task automatic test_reset_drain();
      begin_search();
      core_req = 4'hF;
      for (int i = 0; i < 8; i++) tick();
      #2 reset = 1;
      #1;
      checks++; if (core_grant !== 4'h0) begin errors++; $display("FAIL rd_grant got %h exp 0", core_grant); end
      checks++; if (core_key !== 22'h0) begin errors++; $display("FAIL rd_key got %h exp 0", core_key); end
      checks++; if (keys_issued !== 23'h0) begin errors++; $display("FAIL rd_issued got %0d exp 0", keys_issued); end
      checks++; if (stop_all !== 1'b0 || found !== 1'b0 || exhausted !== 1'b0) begin errors++; $display("FAIL rd_flags got %b%b%b exp 000", stop_all, found, exhausted); end
`ifdef KEY_DISPATCH_PERF_EN
      checks++; if (search_cycles !== 32'h0) begin errors++; $display("FAIL rd_cycles got %0d exp 0", search_cycles); end
`endif
      start = 0;
      core_req = '0;
      m_active = 0;
      m_g = '0;
      for (int i = 0; i < CC; i++) m_assigned[i] = 0;
      @(negedge clk);
      reset = 0;
      tick();
      checks++; if (core_grant !== 4'h0) begin errors++; $display("FAIL rd_idle got %h exp 0", core_grant); end
   endtask

   initial begin
      test_reset();
      test_exhaust();
      test_found();
      test_tie();
      test_single();
      test_abort();
      test_random();
      test_reset_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
